// File: rtl/seg_scan_mux_pkg.sv
// ----------------------------------------------------------------------------
// seg_scan_mux_pkg
// Shared constants for the seven-segment scan driver:
//   SEG_MAX_DIGITS : largest digit count the scanner is built for
//   SEG_OFF        : active-low "all segments dark" pattern
//   SEG_TABLE      : 16-entry active-low hex glyph table (bit 6 = a, bit 0 = g)
//   seg_lookup()   : nibble -> glyph helper used by seg_hex_decode
// ----------------------------------------------------------------------------
package seg_scan_mux_pkg;

   localparam int SEG_MAX_DIGITS = 8;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Packed so that SEG_TABLE[n] is the glyph for hex digit n; entry 15 first.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // d
      7'b0110001,  // C
      7'b1100000,  // b
      7'b0001000,  // A
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

   function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// ----------------------------------------------------------------------------
// seg_hex_decode
// Pure combinational hex nibble to active-low seven-segment glyph lookup.
// Ports:
//   nib  in  4 : hex value to display
//   seg  out 7 : active-low segments, bit 6 = a ... bit 0 = g
// ----------------------------------------------------------------------------
module seg_hex_decode
   import seg_scan_mux_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = seg_lookup(nib);

endmodule

// File: rtl/seg_scan_mux.sv
// ----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed driver for a common-anode seven-segment display of DIGITS
// digits (1..SEG_MAX_DIGITS). One digit slot is shown every 2^DIV_W clocks.
// All display inputs are captured into shadow registers when the scan wraps
// back to digit 0, so a frame never mixes two input values.
//
// Optional feature macro: SEG_BLINK_EN
//   defined     : adds the blink port, BLINK_W parameter and a per-frame blink
//                 counter whose MSB darkens the digits flagged in blink.
//   not defined : no blink port, no counter, no digit ever blinks.
//
// Ports:
//   clk     in  1         : system clock
//   rst     in  1         : synchronous active-high reset
//   x       in  4*DIGITS  : hex value, nibble i -> digit i, digit 0 rightmost
//   dp_in   in  DIGITS    : decimal point request per digit, 1 = lit
//   blank   in  DIGITS    : force digit dark, 1 = dark
//   lz_en   in  1         : leading-zero suppression enable
//   blink   in  DIGITS    : per-digit blink request (SEG_BLINK_EN only)
//   an      out DIGITS    : digit enables, active-low
//   a_to_g  out 7         : segments, active-low, bit 6 = a, bit 0 = g
//   dp      out 1         : decimal point, active-low
// ----------------------------------------------------------------------------
module seg_scan_mux
   import seg_scan_mux_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int DIV_W   = 18
`ifdef SEG_BLINK_EN
   ,
   parameter int BLINK_W = 6
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   x,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  lz_en,
`ifdef SEG_BLINK_EN
   input  logic [DIGITS-1:0]     blink,
`endif
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            a_to_g,
   output logic                  dp
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   // Digit 0 is never a leading zero; every other slot may be suppressed.
   localparam logic [DIGITS-1:0] LZ_OK = ~DIGITS'(1);

   logic [DIV_W-1:0]      div_r;
   logic [IDX_W-1:0]      idx_r;
   logic                  tick_s;
   logic                  frame_start_s;

   logic [4*DIGITS-1:0]   x_sh_r;
   logic [DIGITS-1:0]     dp_sh_r;
   logic [DIGITS-1:0]     blank_sh_r;
   logic                  lz_sh_r;

   logic [DIGITS-1:0]     sel_s;
   logic [DIGITS:0]       zero_from_s;
   logic [3:0]            nib_s;
   logic [6:0]            seg_s;
   logic                  dp_sel_s;
   logic                  blank_sel_s;
   logic                  lz_hit_s;
   logic                  blink_dark_s;
   logic                  dark_s;

   logic [DIGITS-1:0]     an_r;
   logic [6:0]            seg_r;
   logic                  dp_r;

   assign tick_s        = &div_r;
   assign frame_start_s = tick_s & (idx_r == IDX_LAST);

   // Free-running prescaler; tick fires when it is all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + DIV_W'(1);
      end
   end

   // Scan index; explicit wrap so non-power-of-two digit counts never reach DIGITS.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r <= '0;
      end else if (tick_s) begin
         if (idx_r == IDX_LAST) begin
            idx_r <= '0;
         end else begin
            idx_r <= idx_r + IDX_W'(1);
         end
      end else begin
         idx_r <= idx_r;
      end
   end

   // Shadow registers, captured only on the tick that starts a new frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_sh_r     <= '0;
         dp_sh_r    <= '0;
         blank_sh_r <= '0;
         lz_sh_r    <= 1'b0;
      end else if (frame_start_s) begin
         x_sh_r     <= x;
         dp_sh_r    <= dp_in;
         blank_sh_r <= blank;
         lz_sh_r    <= lz_en;
      end else begin
         x_sh_r     <= x_sh_r;
         dp_sh_r    <= dp_sh_r;
         blank_sh_r <= blank_sh_r;
         lz_sh_r    <= lz_sh_r;
      end
   end

   // Slot selection: one-hot select, selected nibble/dp/blank and leading-zero test.
   // zero_from_s[i] is set when shadow nibbles i..DIGITS-1 are all zero.
   always_comb begin
      sel_s               = '0;
      zero_from_s         = '0;
      zero_from_s[DIGITS] = 1'b1;
      nib_s               = 4'h0;
      dp_sel_s            = 1'b0;
      blank_sel_s         = 1'b0;
      lz_hit_s            = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         sel_s[i]       = (idx_r == IDX_W'(i));
         zero_from_s[i] = (x_sh_r[4*i +: 4] == 4'h0) & zero_from_s[i+1];
         nib_s          = nib_s | (sel_s[i] ? x_sh_r[4*i +: 4] : 4'h0);
         dp_sel_s       = dp_sel_s | (sel_s[i] & dp_sh_r[i]);
         blank_sel_s    = blank_sel_s | (sel_s[i] & blank_sh_r[i]);
         lz_hit_s       = lz_hit_s | (sel_s[i] & zero_from_s[i] & LZ_OK[i]);
      end
   end

`ifdef SEG_BLINK_EN
   logic [BLINK_W-1:0] blink_cnt_r;
   logic [DIGITS-1:0]  blink_sh_r;

   // Blink shadow and per-frame blink counter; the counter MSB is the blink phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_r <= '0;
         blink_sh_r  <= '0;
      end else if (frame_start_s) begin
         blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
         blink_sh_r  <= blink;
      end else begin
         blink_cnt_r <= blink_cnt_r;
         blink_sh_r  <= blink_sh_r;
      end
   end

   // Current slot is darkened while it is flagged and the blink phase is high.
   always_comb begin
      blink_dark_s = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         blink_dark_s = blink_dark_s | (sel_s[i] & blink_sh_r[i]);
      end
      blink_dark_s = blink_dark_s & blink_cnt_r[BLINK_W-1];
   end
`else
   assign blink_dark_s = 1'b0;
`endif

   assign dark_s = blank_sel_s | (lz_sh_r & lz_hit_s) | blink_dark_s;

   seg_hex_decode u_dec (
      .nib (nib_s),
      .seg (seg_s)
   );

   // Registered display outputs for the current slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_r  <= '1;
         seg_r <= SEG_OFF;
         dp_r  <= 1'b1;
      end else if (dark_s) begin
         an_r  <= '1;
         seg_r <= SEG_OFF;
         dp_r  <= 1'b1;
      end else begin
         an_r  <= ~sel_s;
         seg_r <= seg_s;
         dp_r  <= ~dp_sel_s;
      end
   end

   assign an     = an_r;
   assign a_to_g = seg_r;
   assign dp     = dp_r;

endmodule

// File: tb/tb_seg_scan_mux.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_mux
// Three scanners (4, 6 and 1 digits, DIV_W = 2) share one stimulus stream.
// A behavioural model derives the shown slot from the number of clock edges
// since reset, the frame-start load points from that same edge count, and the
// expected glyph from a hex table; outputs are compared every cycle. A few
// directed steps pin the model and the designs to hand-computed glyphs.
// ----------------------------------------------------------------------------
module tb_seg_scan_mux;

   localparam int DIV_W   = 2;
   localparam int PER     = 4;           // 2**DIV_W clocks per slot
   localparam int BLINK_W = 2;
   localparam int DK [3]  = '{4, 6, 1};

   localparam logic [6:0] TAB [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic        clk;
   logic        rst;
   logic [31:0] x_in;
   logic [7:0]  dp_in;
   logic [7:0]  blank_in;
   logic        lz_in;
   logic [7:0]  blink_in;

   logic [3:0]  an4;
   logic [6:0]  seg4;
   logic        dp4;
   logic [5:0]  an6;
   logic [6:0]  seg6;
   logic        dp6;
   logic [0:0]  an1;
   logic [6:0]  seg1;
   logic        dp1;

   int errs   = 0;
   int checks = 0;

   seg_scan_mux #(
      .DIGITS (4),
      .DIV_W  (DIV_W)
`ifdef SEG_BLINK_EN
      ,
      .BLINK_W(BLINK_W)
`endif
   ) dut4 (
      .clk    (clk),
      .rst    (rst),
      .x      (x_in[15:0]),
      .dp_in  (dp_in[3:0]),
      .blank  (blank_in[3:0]),
      .lz_en  (lz_in),
`ifdef SEG_BLINK_EN
      .blink  (blink_in[3:0]),
`endif
      .an     (an4),
      .a_to_g (seg4),
      .dp     (dp4)
   );

   seg_scan_mux #(
      .DIGITS (6),
      .DIV_W  (DIV_W)
`ifdef SEG_BLINK_EN
      ,
      .BLINK_W(BLINK_W)
`endif
   ) dut6 (
      .clk    (clk),
      .rst    (rst),
      .x      (x_in[23:0]),
      .dp_in  (dp_in[5:0]),
      .blank  (blank_in[5:0]),
      .lz_en  (lz_in),
`ifdef SEG_BLINK_EN
      .blink  (blink_in[5:0]),
`endif
      .an     (an6),
      .a_to_g (seg6),
      .dp     (dp6)
   );

   seg_scan_mux #(
      .DIGITS (1),
      .DIV_W  (DIV_W)
`ifdef SEG_BLINK_EN
      ,
      .BLINK_W(BLINK_W)
`endif
   ) dut1 (
      .clk    (clk),
      .rst    (rst),
      .x      (x_in[3:0]),
      .dp_in  (dp_in[0:0]),
      .blank  (blank_in[0:0]),
      .lz_en  (lz_in),
`ifdef SEG_BLINK_EN
      .blink  (blink_in[0:0]),
`endif
      .an     (an1),
      .a_to_g (seg1),
      .dp     (dp1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_e   [3];   // edges since reset release
   logic [31:0] m_x   [3];
   logic [7:0]  m_dp  [3];
   logic [7:0]  m_bl  [3];
   logic        m_lz  [3];
   logic [7:0]  m_blk [3];
   int          m_bc  [3];   // frames started since reset
   logic [7:0]  e_an  [3];
   logic [6:0]  e_seg [3];
   logic        e_dp  [3];
   logic        m_valid = 1'b0;

   function automatic void model_slot(input int d, input int idx, input logic [31:0] xs,
                                      input logic [7:0] dps, input logic [7:0] bls,
                                      input logic lzs, input logic bdark,
                                      output logic [7:0] an_o, output logic [6:0] seg_o,
                                      output logic dp_o);
      logic upper_zero;
      int   nib;
      nib        = int'((xs >> (4 * idx)) & 32'hF);
      upper_zero = 1'b1;
      for (int j = idx; j < d; j++) begin
         if (((xs >> (4 * j)) & 32'hF) != 32'h0) upper_zero = 1'b0;
      end
      if (bls[idx] || (lzs && idx > 0 && upper_zero) || bdark) begin
         an_o  = 8'hFF;
         seg_o = 7'h7F;
         dp_o  = 1'b1;
      end else begin
         an_o  = ~(8'h01 << idx);
         seg_o = TAB[nib];
         dp_o  = ~dps[idx];
      end
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_e[k]   = 0;
            m_x[k]   = 32'h0;
            m_dp[k]  = 8'h0;
            m_bl[k]  = 8'h0;
            m_lz[k]  = 1'b0;
            m_blk[k] = 8'h0;
            m_bc[k]  = 0;
            e_an[k]  = 8'hFF;
            e_seg[k] = 7'h7F;
            e_dp[k]  = 1'b1;
         end else begin
            int   idx;
            logic bdark;
            idx   = (m_e[k] / PER) % DK[k];
            bdark = 1'b0;
`ifdef SEG_BLINK_EN
            bdark = m_blk[k][idx] && (((m_bc[k] >> (BLINK_W - 1)) & 1) == 1);
`endif
            model_slot(DK[k], idx, m_x[k], m_dp[k], m_bl[k], m_lz[k], bdark,
                       e_an[k], e_seg[k], e_dp[k]);
            m_e[k] = m_e[k] + 1;
            if (m_e[k] % (PER * DK[k]) == 0) begin
               m_x[k]   = x_in;
               m_dp[k]  = dp_in;
               m_bl[k]  = blank_in;
               m_lz[k]  = lz_in;
               m_blk[k] = blink_in;
               m_bc[k]  = (m_bc[k] + 1) % (1 << BLINK_W);
            end
         end
      end
      m_valid = 1'b1;
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("an_d4",  {24'h0, 4'hF, an4},   {24'h0, e_an[0]});
         chk("seg_d4", {25'h0, seg4},        {25'h0, e_seg[0]});
         chk("dp_d4",  {31'h0, dp4},         {31'h0, e_dp[0]});
         chk("an_d6",  {24'h0, 2'b11, an6},  {24'h0, e_an[1]});
         chk("seg_d6", {25'h0, seg6},        {25'h0, e_seg[1]});
         chk("dp_d6",  {31'h0, dp6},         {31'h0, e_dp[1]});
         chk("an_d1",  {24'h0, 7'h7F, an1},  {24'h0, e_an[2]});
         chk("seg_d1", {25'h0, seg1},        {25'h0, e_seg[2]});
         chk("dp_d1",  {31'h0, dp1},         {31'h0, e_dp[2]});
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit4(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
      chk({name, "_an"},  {28'h0, an4},  {28'h0, a});
      chk({name, "_seg"}, {25'h0, seg4}, {25'h0, s});
      chk({name, "_dp"},  {31'h0, dp4},  {31'h0, d});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst      = 1'b1;
      x_in     = 32'h0000_12AF;
      dp_in    = 8'b0000_0100;
      blank_in = 8'h00;
      lz_in    = 1'b0;
      blink_in = 8'h00;
      step(3);
      lit4("reset", 4'b1111, 7'b1111111, 1'b1);
      rst = 1'b0;
      step(1);                                      // edge 1
      lit4("boot0", 4'b1110, 7'b0000001, 1'b1);
      step(16);                                     // edge 17: slot 0
      lit4("slot0_F", 4'b1110, 7'b0111000, 1'b1);
      step(4);                                      // edge 21: slot 1
      lit4("slot1_A", 4'b1101, 7'b0001000, 1'b1);
      step(1);
      x_in = 32'h0000_3456;                         // mid-frame change
      step(3);                                      // edge 25: slot 2
      lit4("slot2_2", 4'b1011, 7'b0010010, 1'b0);
      step(4);                                      // edge 29: slot 3
      lit4("slot3_1", 4'b0111, 7'b1001111, 1'b1);
      step(4);                                      // edge 33: new frame
      lit4("newframe_6", 4'b1110, 7'b0100000, 1'b1);
      chk("d1_an_lit", {31'h0, an1}, 32'h0);
      step(8);                                      // edge 41: idx now 2
      rst = 1'b1;
      step(1);
      lit4("midrst", 4'b1111, 7'b1111111, 1'b1);
      rst   = 1'b0;
      x_in  = 32'h0000_0005;
      dp_in = 8'h00;
      lz_in = 1'b1;
      step(1);                                      // edge 1
      lit4("restart0", 4'b1110, 7'b0000001, 1'b1);
      step(16);                                     // edge 17
      lit4("lz_slot0", 4'b1110, 7'b0100100, 1'b1);
      step(4);                                      // edge 21
      lit4("lz_slot1", 4'b1111, 7'b1111111, 1'b1);
      x_in = 32'h0;
      step(8);                                      // edge 29
      lit4("lz_slot3", 4'b1111, 7'b1111111, 1'b1);
      step(4);                                      // edge 33
      lit4("lz_zero", 4'b1110, 7'b0000001, 1'b1);

      // Non-power-of-two blanking pattern held over several frames.
      x_in     = 32'h00AB_CDEF;
      lz_in    = 1'b0;
      blank_in = 8'b0010_0001;
      blink_in = 8'b0000_0001;
      step(120);

      // Randomised phase with occasional reset pulses.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            x_in     = $urandom >> (4 * $urandom_range(0, 7));
            dp_in    = 8'($urandom);
            blank_in = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            lz_in    = 1'($urandom);
            blink_in = 8'($urandom);
         end
         rst = ($urandom_range(0, 299) == 0);
         step(1);
      end
      rst = 1'b0;
      step(2);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
